// File: rtl/awg_pkg.sv
// Shared constants for the AWG UART command path: framing bytes, opcodes,
// error codes and the command parser state encoding.
package awg_pkg;

   localparam logic [7:0] SYNC_BYTE     = 8'hA5;
   localparam logic [7:0] OP_REG_WR     = 8'h01;
   localparam logic [7:0] OP_WAVE_BURST = 8'h02;

   localparam logic [1:0] ERR_NONE    = 2'd0;
   localparam logic [1:0] ERR_BAD_OP  = 2'd1;
   localparam logic [1:0] ERR_BAD_CHK = 2'd2;
   localparam logic [1:0] ERR_TIMEOUT = 2'd3;

   typedef logic [2:0] state_t;

   localparam state_t ST_IDLE  = 3'd0;
   localparam state_t ST_OP    = 3'd1;
   localparam state_t ST_ADDR0 = 3'd2;
   localparam state_t ST_ADDR1 = 3'd3;
   localparam state_t ST_CNT   = 3'd4;
   localparam state_t ST_DH    = 3'd5;
   localparam state_t ST_DL    = 3'd6;
   localparam state_t ST_CHK   = 3'd7;

endpackage

// File: rtl/uart_gap_timer.sv
// Inter-byte gap timer: down-counter reloaded on every received byte,
// expire is high while running and the count has reached terminal zero.
module uart_gap_timer #(
   parameter logic [31:0] TIMEOUT_CYCLES = 32'd1041600
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clear,
   input  logic run,
   output logic expire
);

   logic [31:0] remaining;

   // Reload to N-1 so expiry lines up with the N-th clock after the last byte.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         remaining <= '0;
      end else if (clear) begin
         remaining <= TIMEOUT_CYCLES - 32'd1;
      end else if (run && (remaining != '0)) begin
         remaining <= remaining - 32'd1;
      end
   end

   assign expire = run && (remaining == '0);

endmodule

// File: rtl/uart_cmd_ctrl.sv
// Framed UART command parser: drives the register-file and waveform-RAM
// write ports, validates the XOR checksum and aborts stalled frames.
//
//  state    | meaning
//  ---------+-----------------------------------------------
//  IDLE     | hunting for SYNC, other bytes dropped
//  OP       | expecting opcode
//  ADDR0    | burst: expecting address high byte
//  ADDR1    | expecting address low byte (reg addr or burst AL)
//  CNT      | burst: expecting sample count (0 = 256)
//  DH       | expecting data high byte
//  DL       | expecting data low byte; bursts write here
//  CHK      | expecting checksum
module uart_cmd_ctrl
   import awg_pkg::*;
#(
   parameter int unsigned WAVE_AW        = 10,
   parameter logic [31:0] TIMEOUT_CYCLES = 32'd1041600
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [7:0]         rx_data,
   input  logic               rx_valid,
   output logic               reg_we,
   output logic [7:0]         reg_addr,
   output logic [15:0]        reg_wdata,
   output logic               wave_we,
   output logic [WAVE_AW-1:0] wave_addr,
   output logic [15:0]        wave_wdata,
   output logic               busy,
   output logic               cmd_done,
   output logic               cmd_err,
   output logic [1:0]         err_code
);

   state_t             state;
   logic               is_burst;
   logic [7:0]         chk_acc;
   logic [7:0]         addr_hi;
   logic [7:0]         addr_lo;
   logic [7:0]         data_hi;
   logic [7:0]         data_lo;
   logic [8:0]         samples_left;
   logic [WAVE_AW-1:0] wave_ptr;
   logic               timeout;

   assign busy = (state != ST_IDLE);

   uart_gap_timer #(
      .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
   ) u_gap_timer (
      .clk   (clk),
      .rst_n (rst_n),
      .clear (rx_valid),
      .run   (busy),
      .expire(timeout)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= ST_IDLE;
         is_burst     <= 1'b0;
         chk_acc      <= '0;
         addr_hi      <= '0;
         addr_lo      <= '0;
         data_hi      <= '0;
         data_lo      <= '0;
         samples_left <= '0;
         wave_ptr     <= '0;
         reg_we       <= 1'b0;
         reg_addr     <= '0;
         reg_wdata    <= '0;
         wave_we      <= 1'b0;
         wave_addr    <= '0;
         wave_wdata   <= '0;
         cmd_done     <= 1'b0;
         cmd_err      <= 1'b0;
         err_code     <= ERR_NONE;
      end else begin
         reg_we   <= 1'b0;
         wave_we  <= 1'b0;
         cmd_done <= 1'b0;
         cmd_err  <= 1'b0;
         // A byte arriving on the expiry cycle takes priority over the timeout.
         if (rx_valid) begin
            case (state)
               ST_IDLE: begin
                  if (rx_data == SYNC_BYTE) begin
                     state   <= ST_OP;
                     chk_acc <= '0;
                  end
               end
               ST_OP: begin
                  chk_acc <= rx_data;
                  if (rx_data == OP_REG_WR) begin
                     is_burst <= 1'b0;
                     state    <= ST_ADDR1;
                  end else if (rx_data == OP_WAVE_BURST) begin
                     is_burst <= 1'b1;
                     state    <= ST_ADDR0;
                  end else begin
                     state    <= ST_IDLE;
                     cmd_err  <= 1'b1;
                     err_code <= ERR_BAD_OP;
                  end
               end
               ST_ADDR0: begin
                  chk_acc <= chk_acc ^ rx_data;
                  addr_hi <= rx_data;
                  state   <= ST_ADDR1;
               end
               ST_ADDR1: begin
                  chk_acc  <= chk_acc ^ rx_data;
                  addr_lo  <= rx_data;
                  wave_ptr <= WAVE_AW'({addr_hi, rx_data});
                  state    <= is_burst ? ST_CNT : ST_DH;
               end
               ST_CNT: begin
                  chk_acc      <= chk_acc ^ rx_data;
                  samples_left <= (rx_data == 8'd0) ? 9'd256 : {1'b0, rx_data};
                  state        <= ST_DH;
               end
               ST_DH: begin
                  chk_acc <= chk_acc ^ rx_data;
                  data_hi <= rx_data;
                  state   <= ST_DL;
               end
               ST_DL: begin
                  chk_acc <= chk_acc ^ rx_data;
                  data_lo <= rx_data;
                  state   <= ST_CHK;
                  if (is_burst) begin
                     wave_we      <= 1'b1;
                     wave_addr    <= wave_ptr;
                     wave_wdata   <= {data_hi, rx_data};
                     wave_ptr     <= wave_ptr + 1'b1;
                     samples_left <= samples_left - 9'd1;
                     if (samples_left != 9'd1) begin
                        state <= ST_DH;
                     end
                  end
               end
               ST_CHK: begin
                  state <= ST_IDLE;
                  if (rx_data == chk_acc) begin
                     cmd_done <= 1'b1;
                     if (!is_burst) begin
                        reg_we    <= 1'b1;
                        reg_addr  <= addr_lo;
                        reg_wdata <= {data_hi, data_lo};
                     end
                  end else begin
                     cmd_err  <= 1'b1;
                     err_code <= ERR_BAD_CHK;
                  end
               end
               default: state <= ST_IDLE;
            endcase
         end else if (timeout) begin
            state    <= ST_IDLE;
            cmd_err  <= 1'b1;
            err_code <= ERR_TIMEOUT;
         end
      end
   end

endmodule

// File: tb/tb_uart_cmd_ctrl.sv
// Directed bench for uart_cmd_ctrl: register writes, bursts with wrap and
// full-length count, bad opcode/checksum, timeout edge and mid-frame reset.
module tb_uart_cmd_ctrl;

   logic        clk;
   logic        rst_n;
   logic [7:0]  rx_data;
   logic        rx_valid;
   logic        reg_we;
   logic [7:0]  reg_addr;
   logic [15:0] reg_wdata;
   logic        wave_we;
   logic [9:0]  wave_addr;
   logic [15:0] wave_wdata;
   logic        busy;
   logic        cmd_done;
   logic        cmd_err;
   logic [1:0]  err_code;

   int n_checks = 0;
   int n_pass   = 0;
   int n_reg    = 0;
   int n_wave   = 0;
   int n_done   = 0;
   int n_err    = 0;
   logic [9:0]  last_wa;
   logic [15:0] last_wd;

   uart_cmd_ctrl #(
      .WAVE_AW       (10),
      .TIMEOUT_CYCLES(32'd100)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .rx_data   (rx_data),
      .rx_valid  (rx_valid),
      .reg_we    (reg_we),
      .reg_addr  (reg_addr),
      .reg_wdata (reg_wdata),
      .wave_we   (wave_we),
      .wave_addr (wave_addr),
      .wave_wdata(wave_wdata),
      .busy      (busy),
      .cmd_done  (cmd_done),
      .cmd_err   (cmd_err),
      .err_code  (err_code)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (reg_we)   n_reg++;
      if (cmd_done) n_done++;
      if (cmd_err)  n_err++;
      if (wave_we) begin
         n_wave++;
         last_wa = wave_addr;
         last_wd = wave_wdata;
      end
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
   endtask

   // Called on a falling edge; returns on the next falling edge, after the
   // byte has been sampled, so its registered effects are visible.
   task automatic send(input logic [7:0] b);
      rx_data  = b;
      rx_valid = 1'b1;
      @(negedge clk);
      rx_valid = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic clr_counts();
      n_reg  = 0;
      n_wave = 0;
      n_done = 0;
      n_err  = 0;
   endtask

   initial begin
      logic       seen;
      logic [7:0] chk;
      logic [7:0] dh;
      logic [7:0] dl;

      rst_n    = 1'b0;
      rx_valid = 1'b0;
      rx_data  = 8'h00;
      idle(3);
      check("rst_strobes", {reg_we, wave_we, cmd_done, cmd_err, busy}, 0);
      check("rst_reg", {reg_addr, reg_wdata}, 0);
      check("rst_wave", {wave_addr, wave_wdata}, 0);
      check("rst_err_code", err_code, 0);
      rst_n = 1'b1;
      idle(2);
      clr_counts();

      // register write
      send(8'hA5); send(8'h01); send(8'h10); send(8'h12); send(8'h34);
      check("reg_busy", busy, 1);
      send(8'h37);
      check("reg_we", reg_we, 1);
      check("reg_addr", reg_addr, 8'h10);
      check("reg_wdata", reg_wdata, 16'h1234);
      check("reg_done", cmd_done, 1);
      check("reg_busy_end", busy, 0);
      idle(2);
      check("reg_counts", {n_reg[7:0], n_done[7:0], n_err[7:0]}, 24'h010100);
      clr_counts();

      // bad checksum
      send(8'hA5); send(8'h01); send(8'h10); send(8'h12); send(8'h34); send(8'h00);
      check("badchk_err", {cmd_err, cmd_done, reg_we, busy}, 4'b1000);
      check("badchk_code", err_code, 2);
      check("badchk_hold", {reg_addr, reg_wdata}, 24'h101234);
      idle(2);
      check("badchk_counts", {n_reg[7:0], n_done[7:0], n_err[7:0]}, 24'h000001);
      clr_counts();

      // burst wrapping at the top of the address space
      send(8'hA5); send(8'h02); send(8'h03); send(8'hFF); send(8'h02);
      send(8'h00); send(8'h01);
      check("burst_w0", {wave_we, wave_addr, wave_wdata}, {1'b1, 10'h3FF, 16'h0001});
      send(8'h80); send(8'h00);
      check("burst_w1", {wave_we, wave_addr, wave_wdata}, {1'b1, 10'h000, 16'h8000});
      send(8'h7D);
      check("burst_done", {cmd_done, cmd_err, wave_we, busy}, 4'b1000);
      check("burst_hold", {wave_addr, wave_wdata}, {10'h000, 16'h8000});
      idle(2);
      check("burst_counts", {n_wave[7:0], n_done[7:0], n_err[7:0], n_reg[7:0]}, 32'h02010000);
      clr_counts();

      // bad opcode, trailing bytes dropped, then a clean write
      send(8'hA5); send(8'h07);
      check("badop_err", {cmd_err, busy}, 2'b10);
      check("badop_code", err_code, 1);
      send(8'h55); send(8'hAA);
      idle(2);
      check("badop_idle", busy, 0);
      check("badop_counts", {n_err[7:0], n_done[7:0]}, 16'h0100);
      send(8'hA5); send(8'h01); send(8'h20); send(8'hAB); send(8'hCD); send(8'h47);
      check("after_badop_reg", {reg_we, reg_addr, reg_wdata}, {1'b1, 8'h20, 16'hABCD});
      check("after_badop_code", err_code, 1);
      idle(2);
      clr_counts();

      // timeout after exactly 100 idle clocks
      send(8'hA5); send(8'h01); send(8'h10);
      seen = 1'b0;
      repeat (99) begin
         @(negedge clk);
         if (cmd_err) seen = 1'b1;
      end
      check("tmo_early", {seen, busy}, 2'b01);
      @(negedge clk);
      check("tmo_err", {cmd_err, busy}, 2'b10);
      check("tmo_code", err_code, 3);
      idle(2);
      clr_counts();

      // byte on the expiry cycle suppresses the timeout
      send(8'hA5); send(8'h01); send(8'h10);
      idle(99);
      send(8'h12); send(8'h34); send(8'h37);
      check("tmo_race_reg", {reg_we, cmd_done}, 2'b11);
      idle(2);
      check("tmo_race_counts", {n_err[7:0], n_reg[7:0]}, 16'h0001);
      clr_counts();

      // N=0 burst: 256 samples from 0x010
      send(8'hA5); send(8'h02); send(8'h00); send(8'h10); send(8'h00);
      chk = 8'h02 ^ 8'h00 ^ 8'h10 ^ 8'h00;
      for (int i = 0; i < 256; i++) begin
         dh  = 8'(i);
         dl  = ~8'(i);
         chk = chk ^ dh ^ dl;
         send(dh);
         send(dl);
      end
      send(chk);
      check("n0_done", {cmd_done, cmd_err}, 2'b10);
      idle(2);
      check("n0_count", n_wave, 256);
      check("n0_last", {last_wa, last_wd}, {10'h10F, 16'hFF00});
      clr_counts();

      // reset in the middle of a burst
      send(8'hA5); send(8'h02); send(8'h00); send(8'h00); send(8'h04);
      send(8'h00); send(8'h01);
      check("mid_wave", {wave_we, wave_addr, wave_wdata}, {1'b1, 10'h000, 16'h0001});
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      clr_counts();
      check("mid_rst_strobes", {reg_we, wave_we, cmd_done, cmd_err, busy}, 0);
      check("mid_rst_regs", {reg_addr, reg_wdata, err_code}, 0);
      check("mid_rst_wave", {wave_addr, wave_wdata}, 0);
      idle(2);
      rst_n = 1'b1;
      idle(3);
      check("mid_release", {busy, n_err[7:0], n_done[7:0], n_wave[7:0]}, 0);
      send(8'hA5); send(8'h01); send(8'h10); send(8'h12); send(8'h34); send(8'h37);
      check("mid_after_reg", {reg_we, reg_addr, reg_wdata, cmd_done}, {1'b1, 8'h10, 16'h1234, 1'b1});

      idle(2);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
